bit_scan_ctrl: RTL and testbench

BIT_SCAN_CTRL -- requirements
Module: bit_scan_ctrl

---
 rtl/bit_scan_ctrl.sv | 117 +++++++++++
 tb/tb_bit_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_ctrl.sv
// Purpose: scans a captured 16-bit word for the first bit equal to a polarity,
//          starting at a given index and stepping upward (optionally wrapping).
// Latency: match at offset k from the start index -> Done k+1 edges after Start accept;
//          exhaustive no-match -> 16 edges (or fewer when wrap is disabled).
// Backpressure: none; Start is only sampled in IDLE, Abort cancels an active scan.
//
// Ports:
//   Clock, Resetn        : clock, asynchronous active-low reset
//   Start, Abort         : request pulse (IDLE only), synchronous cancel (SCAN only)
//   A, SI, P             : operand word, start index, match polarity (captured on Start)
//   BS                   : registered bit-select index driven to the bit-test datapath
//   Busy, Done           : state decodes (SCAN, one-cycle DONE)
//   Found, Index, Tested : result of the last scan, held until the next accepted Start
module bit_scan_ctrl #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Abort,
  input  logic [15:0] A,
  input  logic [3:0]  SI,
  input  logic        P,
  output logic [3:0]  BS,
  output logic        Busy,
  output logic        Done,
  output logic        Found,
  output logic [3:0]  Index,
  output logic [4:0]  Tested
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] a_q;
  logic [3:0]  si_q;
  logic        p_q;
  logic [3:0]  bs_q;
  logic        found_q;
  logic [3:0]  index_q;
  logic [4:0]  tested_q;

  logic        bit_hit;
  logic [4:0]  tested_d;
  logic        scan_end;

  // Bit under test comes from the captured word, so input changes mid-scan are invisible.
  assign bit_hit  = (a_q[bs_q] == p_q);
  assign tested_d = tested_q + 5'd1;
  // Stop on the 16th evaluation, or at the top bit when wrapping is disabled.
  assign scan_end = (tested_d == 5'd16) || (!WRAP_EN && (bs_q == 4'd15));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      si_q     <= '0;
      p_q      <= 1'b0;
      bs_q     <= '0;
      found_q  <= 1'b0;
      index_q  <= '0;
      tested_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            a_q      <= A;
            si_q     <= SI;
            p_q      <= P;
            bs_q     <= SI;
            tested_q <= '0;
            found_q  <= 1'b0;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Abort takes priority over a match evaluated on the same edge.
          if (Abort) begin
            found_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tested_q <= tested_d;
            if (bit_hit) begin
              found_q <= 1'b1;
              index_q <= bs_q;
              state_q <= ST_DONE;
            end else if (scan_end) begin
              found_q <= 1'b0;
              index_q <= si_q;
              state_q <= ST_DONE;
            end else begin
              bs_q <= bs_q + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy   = (state_q == ST_SCAN);
  assign Done   = (state_q == ST_DONE);
  assign BS     = bs_q;
  assign Found  = found_q;
  assign Index  = index_q;
  assign Tested = tested_q;

endmodule

// File: tb/tb_bit_scan_ctrl.sv
// Purpose: directed bench for bit_scan_ctrl, wrap and no-wrap instances side by side.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_bit_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [3:0]  si;
  logic        p;

  logic [3:0]  bs_w,  bs_n;
  logic        busy_w, busy_n;
  logic        done_w, done_n;
  logic        found_w, found_n;
  logic [3:0]  index_w, index_n;
  logic [4:0]  tested_w, tested_n;

  int n_chk;
  int n_pass;

  bit_scan_ctrl #(.WRAP_EN(1'b1)) dut_w (
    .Clock (clk), .Resetn(rst_n), .Start(start), .Abort(abort),
    .A(a), .SI(si), .P(p),
    .BS(bs_w), .Busy(busy_w), .Done(done_w), .Found(found_w),
    .Index(index_w), .Tested(tested_w)
  );

  bit_scan_ctrl #(.WRAP_EN(1'b0)) dut_n (
    .Clock (clk), .Resetn(rst_n), .Start(start), .Abort(abort),
    .A(a), .SI(si), .P(p),
    .BS(bs_n), .Busy(busy_n), .Done(done_n), .Found(found_n),
    .Index(index_n), .Tested(tested_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [15:0] av, input logic [3:0] siv, input logic pv);
    a = av; si = siv; p = pv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges until each instance raises Done; 0 means it never did within the bound.
  task automatic wait_both(output int ew, output int en);
    ew = 0; en = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_w && ew == 0) ew = i;
      if (done_n && en == 0) en = i;
      if (ew != 0 && en != 0) break;
    end
  endtask

  // Count Done pulses seen on either instance over a window.
  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done_w || done_n) seen++;
    end
  endtask

  int ew, en, seen;

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; si = '0; p = 1'b0;

    #3;
    check("reset_w", {bs_w, busy_w, done_w, found_w, index_w, tested_w}, 32'd0);
    check("reset_n", {bs_n, busy_n, done_n, found_n, index_n, tested_n}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Match at offset 4 from index 0.
    start_scan(16'h0010, 4'd0, 1'b1);
    check("t1_busy", busy_w, 1);
    check("t1_bs0", bs_w, 0);
    tick(); tick();
    check("t1_bs2", bs_w, 2);
    wait_both(ew, en);
    check("t1_edges", ew + 2, 5);
    check("t1_res", {found_w, index_w, tested_w}, {1'b1, 4'd4, 5'd5});
    check("t1_bs4", bs_w, 4);
    tick();
    check("t1_done_1cyc", {done_w, busy_w}, 2'b00);
    check("t1_hold", {found_w, index_w, tested_w}, {1'b1, 4'd4, 5'd5});

    // Wrap from 14 to 0 vs stop at 15.
    start_scan(16'h0001, 4'd14, 1'b1);
    wait_both(ew, en);
    check("t2_edges_w", ew, 3);
    check("t2_res_w", {found_w, index_w, tested_w}, {1'b1, 4'd0, 5'd3});
    check("t2_edges_n", en, 2);
    check("t2_res_n", {found_n, index_n, tested_n}, {1'b0, 4'd14, 5'd2});
    tick();

    // Immediate match, then exhaustive no-match.
    start_scan(16'hFFFF, 4'd5, 1'b1);
    wait_both(ew, en);
    check("t3a_edges", ew, 1);
    check("t3a_res", {found_w, index_w, tested_w}, {1'b1, 4'd5, 5'd1});
    tick();
    start_scan(16'hFFFF, 4'd3, 1'b0);
    wait_both(ew, en);
    check("t3b_edges_w", ew, 16);
    check("t3b_res_w", {found_w, index_w, tested_w}, {1'b0, 4'd3, 5'd16});
    check("t3b_edges_n", en, 13);
    check("t3b_res_n", {found_n, index_n, tested_n}, {1'b0, 4'd3, 5'd13});
    tick();

    // Second Start and operand change during SCAN must not disturb the scan.
    start_scan(16'h8000, 4'd0, 1'b1);
    a = 16'h0001; si = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_both(ew, en);
    check("t4_edges", ew + 1, 16);
    check("t4_res_w", {found_w, index_w, tested_w}, {1'b1, 4'd15, 5'd16});
    tick();

    // Abort after three evaluations.
    start_scan(16'h0000, 4'd0, 1'b1);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5a_state", {busy_w, done_w, found_w}, 3'b000);
    check("t5a_tested", tested_w, 3);
    check("t5a_index", index_w, 15);
    count_done(20, seen);
    check("t5a_no_done", seen, 0);

    // Abort on the same edge a match would be found.
    start_scan(16'h0010, 4'd0, 1'b1);
    tick(); tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5b_state", {busy_w, done_w, found_w}, 3'b000);
    check("t5b_tested", tested_w, 4);
    count_done(10, seen);
    check("t5b_no_done", seen, 0);

    // Abort in IDLE does not block Start.
    abort = 1'b1;
    start_scan(16'h0004, 4'd0, 1'b1);
    abort = 1'b0;
    check("t5c_busy", busy_w, 1);
    wait_both(ew, en);
    check("t5c_res", {found_w, index_w, tested_w}, {1'b1, 4'd2, 5'd3});
    tick();

    // Reset mid-scan, between edges.
    start_scan(16'h0000, 4'd0, 1'b1);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_w", {bs_w, busy_w, done_w, found_w, index_w, tested_w}, 32'd0);
    check("t6_rst_n", {bs_n, busy_n, done_n, found_n, index_n, tested_n}, 32'd0);
    count_done(3, seen);
    rst_n = 1'b1;
    begin
      int seen2;
      count_done(5, seen2);
      check("t6_no_done", seen + seen2, 0);
    end
    start_scan(16'h0002, 4'd0, 1'b1);
    wait_both(ew, en);
    check("t6_edges", ew, 2);
    check("t6_res", {found_w, index_w, tested_w}, {1'b1, 4'd1, 5'd2});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
